// File: rtl/byteswap_control_pkg.sv
// Shared constants and state types for the byteswap kernel control register file.
package byteswap_control_pkg;

    // Register byte offsets
    localparam logic [5:0] ADDR_AP_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_GIE         = 6'h04;
    localparam logic [5:0] ADDR_IER         = 6'h08;
    localparam logic [5:0] ADDR_ISR         = 6'h0C;
    localparam logic [5:0] ADDR_XFER_SIZE   = 6'h10;
    localparam logic [5:0] ADDR_GMEM_PTR_LO = 6'h18;
    localparam logic [5:0] ADDR_GMEM_PTR_HI = 6'h1C;

    // AP_CTRL bit positions
    localparam int unsigned AP_START_BIT     = 0;
    localparam int unsigned AP_DONE_BIT      = 1;
    localparam int unsigned AP_IDLE_BIT      = 2;
    localparam int unsigned AP_READY_BIT     = 3;
    localparam int unsigned AUTO_RESTART_BIT = 7;

    typedef enum logic [1:0] {WrReset, WrIdle, WrData, WrResp} wr_state_t;
    typedef enum logic [1:0] {RdReset, RdIdle, RdData} rd_state_t;

    // Merge write data into an existing word, one byte lane per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/byteswap_control_s_axi.sv
// AXI4-Lite control/argument register file for the byteswap kernel core.
module byteswap_control_s_axi
    import byteswap_control_pkg::*;
#(
    parameter int unsigned C_S_AXI_CONTROL_ADDR_WIDTH = 6,
    parameter int unsigned C_S_AXI_CONTROL_DATA_WIDTH = 32,
    parameter int unsigned C_XFER_SIZE_WIDTH          = 32,
    parameter int unsigned C_M_AXI_GMEM_ADDR_WIDTH    = 64
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst_n,
    input  logic                                    s_axi_control_AWVALID,
    output logic                                    s_axi_control_AWREADY,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_AWADDR,
    input  logic                                    s_axi_control_WVALID,
    output logic                                    s_axi_control_WREADY,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_WDATA,
    input  logic [C_S_AXI_CONTROL_DATA_WIDTH/8-1:0] s_axi_control_WSTRB,
    output logic                                    s_axi_control_BVALID,
    input  logic                                    s_axi_control_BREADY,
    output logic [1:0]                              s_axi_control_BRESP,
    input  logic                                    s_axi_control_ARVALID,
    output logic                                    s_axi_control_ARREADY,
    input  logic [C_S_AXI_CONTROL_ADDR_WIDTH-1:0]   s_axi_control_ARADDR,
    output logic                                    s_axi_control_RVALID,
    input  logic                                    s_axi_control_RREADY,
    output logic [C_S_AXI_CONTROL_DATA_WIDTH-1:0]   s_axi_control_RDATA,
    output logic [1:0]                              s_axi_control_RRESP,
    output logic                                    interrupt,
    output logic                                    ap_start,
    input  logic                                    ap_done,
    input  logic                                    ap_idle,
    input  logic                                    ap_ready,
    output logic [C_XFER_SIZE_WIDTH-1:0]            xfer_size,
    output logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]      gmem_ptr
);

    wr_state_t   wr_state_q, wr_state_d;
    rd_state_t   rd_state_q, rd_state_d;
    logic [5:0]  waddr_q, waddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_mux;
    logic        ap_start_q, ap_start_d;
    logic        ap_done_q, ap_done_d;
    logic        auto_restart_q, auto_restart_d;
    logic        gie_q, gie_d;
    logic [1:0]  ier_q, ier_d;
    logic [1:0]  isr_q, isr_d;
    logic [31:0] xfer_size_q, xfer_size_d;
    logic [63:0] gmem_ptr_q, gmem_ptr_d;

    logic        w_hs, ar_hs;
    logic [5:0]  raddr;

    assign w_hs  = s_axi_control_WVALID && (wr_state_q == WrData);
    assign ar_hs = s_axi_control_ARVALID && (rd_state_q == RdIdle);
    assign raddr = s_axi_control_ARADDR[5:0];

    // Write channel sequencing: address, then data, then response
    always_comb begin
        wr_state_d = wr_state_q;
        waddr_d    = waddr_q;
        case (wr_state_q)
            WrReset: wr_state_d = WrIdle;
            WrIdle: begin
                if (s_axi_control_AWVALID) begin
                    wr_state_d = WrData;
                    waddr_d    = s_axi_control_AWADDR[5:0];
                end
            end
            WrData:  if (s_axi_control_WVALID) wr_state_d = WrResp;
            WrResp:  if (s_axi_control_BREADY) wr_state_d = WrIdle;
            default: wr_state_d = WrIdle;
        endcase
    end

    // Read data selection for the address presented on AR
    always_comb begin
        rd_mux = '0;
        case (raddr)
            ADDR_AP_CTRL: begin
                rd_mux[AP_START_BIT]     = ap_start_q;
                rd_mux[AP_DONE_BIT]      = ap_done_q;
                rd_mux[AP_IDLE_BIT]      = ap_idle;
                rd_mux[AP_READY_BIT]     = ap_ready;
                rd_mux[AUTO_RESTART_BIT] = auto_restart_q;
            end
            ADDR_GIE:         rd_mux[0]   = gie_q;
            ADDR_IER:         rd_mux[1:0] = ier_q;
            ADDR_ISR:         rd_mux[1:0] = isr_q;
            ADDR_XFER_SIZE:   rd_mux      = xfer_size_q;
            ADDR_GMEM_PTR_LO: rd_mux      = gmem_ptr_q[31:0];
            ADDR_GMEM_PTR_HI: rd_mux      = gmem_ptr_q[63:32];
            default:          rd_mux      = '0;
        endcase
    end

    // Read channel sequencing; data is captured on the AR handshake
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            RdReset: rd_state_d = RdIdle;
            RdIdle: begin
                if (s_axi_control_ARVALID) begin
                    rd_state_d = RdData;
                    rdata_d    = rd_mux;
                end
            end
            RdData:  if (s_axi_control_RREADY) rd_state_d = RdIdle;
            default: rd_state_d = RdIdle;
        endcase
    end

    // Register file next-state: host writes merged with core status events
    always_comb begin
        logic wr_ctrl, wr_gie, wr_ier, wr_isr, wr_xfer, wr_lo, wr_hi;
        wr_ctrl = w_hs && (waddr_q == ADDR_AP_CTRL);
        wr_gie  = w_hs && (waddr_q == ADDR_GIE);
        wr_ier  = w_hs && (waddr_q == ADDR_IER);
        wr_isr  = w_hs && (waddr_q == ADDR_ISR);
        wr_xfer = w_hs && (waddr_q == ADDR_XFER_SIZE);
        wr_lo   = w_hs && (waddr_q == ADDR_GMEM_PTR_LO);
        wr_hi   = w_hs && (waddr_q == ADDR_GMEM_PTR_HI);

        ap_start_d     = ap_start_q;
        ap_done_d      = ap_done_q;
        auto_restart_d = auto_restart_q;
        gie_d          = gie_q;
        ier_d          = ier_q;
        isr_d          = isr_q;
        xfer_size_d    = xfer_size_q;
        gmem_ptr_d     = gmem_ptr_q;

        // Host start request takes priority over the core's ready handshake
        if (wr_ctrl && s_axi_control_WSTRB[0] && s_axi_control_WDATA[AP_START_BIT]) begin
            ap_start_d = 1'b1;
        end else if (ap_ready && !auto_restart_q) begin
            ap_start_d = 1'b0;
        end

        if (wr_ctrl && s_axi_control_WSTRB[0]) begin
            auto_restart_d = s_axi_control_WDATA[AUTO_RESTART_BIT];
        end

        // A fresh done event must not be lost to a coincident clear-on-read
        if (ap_done) begin
            ap_done_d = 1'b1;
        end else if (ar_hs && (raddr == ADDR_AP_CTRL)) begin
            ap_done_d = 1'b0;
        end

        if (wr_gie && s_axi_control_WSTRB[0]) gie_d = s_axi_control_WDATA[0];
        if (wr_ier && s_axi_control_WSTRB[0]) ier_d = s_axi_control_WDATA[1:0];

        for (int n = 0; n < 2; n++) begin
            if (ier_q[n] && ((n == 0) ? ap_done : ap_ready)) begin
                isr_d[n] = 1'b1;
            end else if (wr_isr && s_axi_control_WSTRB[0] && s_axi_control_WDATA[n]) begin
                isr_d[n] = ~isr_q[n];
            end
        end

        if (wr_xfer) begin
            xfer_size_d = apply_strb(xfer_size_q, s_axi_control_WDATA, s_axi_control_WSTRB);
        end
        if (wr_lo) begin
            gmem_ptr_d[31:0] = apply_strb(gmem_ptr_q[31:0], s_axi_control_WDATA,
                                          s_axi_control_WSTRB);
        end
        if (wr_hi) begin
            gmem_ptr_d[63:32] = apply_strb(gmem_ptr_q[63:32], s_axi_control_WDATA,
                                           s_axi_control_WSTRB);
        end
    end

    // State and register storage
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_state_q     <= WrReset;
            rd_state_q     <= RdReset;
            waddr_q        <= '0;
            rdata_q        <= '0;
            ap_start_q     <= 1'b0;
            ap_done_q      <= 1'b0;
            auto_restart_q <= 1'b0;
            gie_q          <= 1'b0;
            ier_q          <= '0;
            isr_q          <= '0;
            xfer_size_q    <= '0;
            gmem_ptr_q     <= '0;
        end else begin
            wr_state_q     <= wr_state_d;
            rd_state_q     <= rd_state_d;
            waddr_q        <= waddr_d;
            rdata_q        <= rdata_d;
            ap_start_q     <= ap_start_d;
            ap_done_q      <= ap_done_d;
            auto_restart_q <= auto_restart_d;
            gie_q          <= gie_d;
            ier_q          <= ier_d;
            isr_q          <= isr_d;
            xfer_size_q    <= xfer_size_d;
            gmem_ptr_q     <= gmem_ptr_d;
        end
    end

    assign s_axi_control_AWREADY = (wr_state_q == WrIdle);
    assign s_axi_control_WREADY  = (wr_state_q == WrData);
    assign s_axi_control_BVALID  = (wr_state_q == WrResp);
    assign s_axi_control_BRESP   = 2'b00;
    assign s_axi_control_ARREADY = (rd_state_q == RdIdle);
    assign s_axi_control_RVALID  = (rd_state_q == RdData);
    assign s_axi_control_RDATA   = rdata_q;
    assign s_axi_control_RRESP   = 2'b00;
    assign interrupt             = gie_q & (|isr_q);
    assign ap_start              = ap_start_q;
    assign xfer_size             = xfer_size_q;
    assign gmem_ptr              = gmem_ptr_q;

endmodule

// File: tb/tb_byteswap_control_s_axi.sv
// Scoreboard bench for the byteswap control register file.
module tb_byteswap_control_s_axi;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [5:0]  awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        interrupt, ap_start, ap_done, ap_idle, ap_ready;
    logic [31:0] xfer_size;
    logic [63:0] gmem_ptr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rq_data[$];
    string       rq_name[$];
    int          bq_cnt = 0;

    always #5 ap_clk = ~ap_clk;

    byteswap_control_s_axi dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .s_axi_control_AWVALID (awvalid),
        .s_axi_control_AWREADY (awready),
        .s_axi_control_AWADDR  (awaddr),
        .s_axi_control_WVALID  (wvalid),
        .s_axi_control_WREADY  (wready),
        .s_axi_control_WDATA   (wdata),
        .s_axi_control_WSTRB   (wstrb),
        .s_axi_control_BVALID  (bvalid),
        .s_axi_control_BREADY  (bready),
        .s_axi_control_BRESP   (bresp),
        .s_axi_control_ARVALID (arvalid),
        .s_axi_control_ARREADY (arready),
        .s_axi_control_ARADDR  (araddr),
        .s_axi_control_RVALID  (rvalid),
        .s_axi_control_RREADY  (rready),
        .s_axi_control_RDATA   (rdata),
        .s_axi_control_RRESP   (rresp),
        .interrupt             (interrupt),
        .ap_start              (ap_start),
        .ap_done               (ap_done),
        .ap_idle               (ap_idle),
        .ap_ready              (ap_ready),
        .xfer_size             (xfer_size),
        .gmem_ptr              (gmem_ptr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every R and B handshake against the scoreboard queues
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n && rvalid && rready) begin
                if (rq_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got 0x%0h expected none", rdata);
                end else begin
                    e = rq_data.pop_front();
                    n = rq_name.pop_front();
                    chk(n, {30'b0, rresp, rdata}, {32'b0, e});
                end
            end
            if (ap_rst_n && bvalid && bready) begin
                if (bq_cnt == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bresp: got %0d expected none", bresp);
                end else begin
                    bq_cnt--;
                    chk("bresp", {62'b0, bresp}, 64'h0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return awready;
            1:       return wready;
            2:       return bvalid;
            3:       return arready;
            4:       return rvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hi(input int sel, input string nm);
        int n = 0;
        while (!sig_of(sel) && n < 20) begin
            tick();
            n++;
        end
        if (!sig_of(sel)) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: got 0 expected 1", nm);
        end
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        tick();
        awvalid = 1'b1;
        awaddr  = a;
        wait_hi(0, "awready");
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b1;
        wdata   = d;
        wstrb   = s;
        wait_hi(1, "wready");
        tick();
        wvalid = 1'b0;
        bq_cnt++;
        bready = 1'b1;
        wait_hi(2, "bvalid");
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] exp, input string nm);
        tick();
        arvalid = 1'b1;
        araddr  = a;
        rq_data.push_back(exp);
        rq_name.push_back(nm);
        wait_hi(3, "arready");
        tick();
        arvalid = 1'b0;
        rready  = 1'b1;
        wait_hi(4, "rvalid");
        tick();
        rready = 1'b0;
    endtask

    task automatic pulse(input logic rdy, input logic dn);
        tick();
        ap_ready = rdy;
        ap_done  = dn;
        tick();
        ap_ready = 1'b0;
        ap_done  = 1'b0;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        ap_done = 1'b0; ap_ready = 1'b0; ap_idle = 1'b1;

        // Reset state
        repeat (3) @(negedge ap_clk);
        chk("rst_handshake", {awready, wready, bvalid, arready, rvalid}, 64'h0);
        chk("rst_outputs", {interrupt, ap_start, rdata}, 64'h0);
        chk("rst_args", {xfer_size, gmem_ptr}, 64'h0);
        ap_rst_n = 1'b1;
        tick();
        tick();
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);

        axi_read(6'h00, 32'h4, "rd_ctrl_reset");
        axi_read(6'h10, 32'h0, "rd_xfer_reset");
        axi_read(6'h18, 32'h0, "rd_ptr_lo_reset");
        axi_read(6'h1C, 32'h0, "rd_ptr_hi_reset");

        // Argument registers and byte strobes
        axi_write(6'h10, 32'h0000_1000, 4'hF);
        axi_write(6'h18, 32'h8000_0000, 4'hF);
        axi_write(6'h1C, 32'h0000_0001, 4'hF);
        chk("xfer_size", xfer_size, 64'h1000);
        chk("gmem_ptr", gmem_ptr, 64'h1_8000_0000);
        axi_read(6'h10, 32'h0000_1000, "rd_xfer");
        axi_read(6'h18, 32'h8000_0000, "rd_ptr_lo");
        axi_read(6'h1C, 32'h0000_0001, "rd_ptr_hi");
        axi_write(6'h10, 32'hFFFF_FFFF, 4'b0011);
        chk("xfer_strb", xfer_size, 64'h0000_FFFF);
        axi_read(6'h10, 32'h0000_FFFF, "rd_xfer_strb");

        // Start / done handshake with clear-on-read
        ap_idle = 1'b0;
        axi_write(6'h00, 32'h1, 4'h1);
        chk("ap_start_set", ap_start, 1);
        pulse(1'b1, 1'b1);
        ap_idle = 1'b1;
        chk("ap_start_clr", ap_start, 0);
        axi_read(6'h00, 32'h6, "rd_ctrl_done");
        axi_read(6'h00, 32'h4, "rd_ctrl_done_cleared");

        // Auto-restart keeps start asserted; writing 0 to start does nothing
        ap_idle = 1'b0;
        axi_write(6'h00, 32'h81, 4'h1);
        pulse(1'b1, 1'b0);
        chk("auto_restart_hold", ap_start, 1);
        axi_read(6'h00, 32'h81, "rd_ctrl_auto");
        axi_write(6'h00, 32'h0, 4'h1);
        chk("start_write0", ap_start, 1);
        pulse(1'b1, 1'b0);
        chk("start_clr_no_auto", ap_start, 0);
        ap_idle = 1'b1;

        // Interrupt path
        axi_write(6'h04, 32'h1, 4'h1);
        axi_write(6'h08, 32'h1, 4'h1);
        chk("irq_quiet", interrupt, 0);
        pulse(1'b0, 1'b1);
        chk("irq_set", interrupt, 1);
        axi_read(6'h0C, 32'h1, "rd_isr");
        axi_write(6'h0C, 32'h1, 4'h1);
        chk("irq_cleared", interrupt, 0);
        axi_read(6'h00, 32'h6, "rd_ctrl_done_irq");
        axi_read(6'h04, 32'h1, "rd_gie");
        axi_read(6'h08, 32'h1, "rd_ier");
        axi_read(6'h20, 32'h0, "rd_unmapped");

        // ap_done on the same edge as the AR handshake to AP_CTRL
        tick();
        arvalid = 1'b1;
        araddr  = 6'h00;
        ap_done = 1'b1;
        rq_data.push_back(32'h4);
        rq_name.push_back("rd_ctrl_race");
        wait_hi(3, "arready");
        tick();
        ap_done = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b1;
        wait_hi(4, "rvalid");
        tick();
        rready = 1'b0;
        axi_read(6'h00, 32'h6, "rd_ctrl_after_race");

        // Write response backpressure
        tick();
        awvalid = 1'b1;
        awaddr  = 6'h10;
        wait_hi(0, "awready");
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b1;
        wdata   = 32'h1234;
        wstrb   = 4'hF;
        wait_hi(1, "wready");
        tick();
        wvalid  = 1'b0;
        awvalid = 1'b1;
        awaddr  = 6'h04;
        for (int i = 0; i < 5; i++) begin
            chk("bvalid_hold", bvalid, 1);
            chk("aw_blocked", awready, 0);
            tick();
        end
        awvalid = 1'b0;
        bq_cnt++;
        bready = 1'b1;
        wait_hi(2, "bvalid");
        tick();
        bready = 1'b0;
        chk("xfer_bp", xfer_size, 64'h1234);

        // Read data backpressure
        tick();
        arvalid = 1'b1;
        araddr  = 6'h10;
        wait_hi(3, "arready");
        tick();
        araddr = 6'h04;
        for (int i = 0; i < 5; i++) begin
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, 64'h1234);
            chk("ar_blocked", arready, 0);
            tick();
        end
        arvalid = 1'b0;
        rq_data.push_back(32'h1234);
        rq_name.push_back("rd_bp");
        rready = 1'b1;
        wait_hi(4, "rvalid");
        tick();
        rready = 1'b0;

        repeat (3) tick();
        chk("rq_drained", rq_data.size(), 0);
        chk("bq_drained", bq_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byteswap_control_s_axi.md
# byteswap_control_s_axi

AXI4-Lite slave register file that sits directly upstream of the byteswap kernel core. It exposes the standard kernel control block (start/done/idle/ready, auto-restart, interrupt) and the `xfer_size` and `gmem_ptr` arguments to the host. It drives `ap_start`, `xfer_size` and `gmem_ptr` into the core, and returns the core's `ap_done`, `ap_idle` and `ap_ready` to the host.

## Interface
- C_S_AXI_CONTROL_ADDR_WIDTH, 6: byte address width; only [5:0] decoded.
- C_S_AXI_CONTROL_DATA_WIDTH, 32: fixed 32; other values unsupported.
- C_XFER_SIZE_WIDTH, 32: width of `xfer_size`.
- C_M_AXI_GMEM_ADDR_WIDTH, 64: width of `gmem_ptr`.

Ports:
- ap_clk  in  1  single clock.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- s_axi_control_AWVALID/AWREADY/AWADDR  in/out/in  1/1/ADDR  write address.
- s_axi_control_WVALID/WREADY/WDATA/WSTRB  in/out/in/in  1/1/32/4  write data.
- s_axi_control_BVALID/BREADY/BRESP  out/in/out  1/1/2  write response.
- s_axi_control_ARVALID/ARREADY/ARADDR  in/out/in  1/1/ADDR  read address.
- s_axi_control_RVALID/RREADY/RDATA/RRESP  out/in/out/out  1/1/32/2  read data.
- interrupt  out  1  level interrupt.
- ap_start  out  1  to core; level, held until `ap_ready`.
- ap_done, ap_idle, ap_ready  in  1 each  from core.
- xfer_size  out  C_XFER_SIZE_WIDTH  argument.
- gmem_ptr  out  C_M_AXI_GMEM_ADDR_WIDTH  argument.

## Operation
- Register map (byte offsets):
  - 0x00 AP_CTRL: b0 start (RW), b1 done (RO, clear-on-read), b2 idle (RO, live), b3 ready (RO, live), b7 auto_restart (RW).
  - 0x04 GIE: b0.
  - 0x08 IER: b0 done, b1 ready.
  - 0x0C ISR: b0 done, b1 ready; writing 1 toggles the bit.
  - 0x10 xfer_size.
  - 0x18 gmem_ptr[31:0].
  - 0x1C gmem_ptr[63:32].
- WSTRB applies per byte to 0x10, 0x18 and 0x1C. Writes to unmapped or read-only bits are ignored. Unmapped reads return 0. BRESP and RRESP are always 2'b00.
- Write FSM states: WRRESET → WRIDLE (AWREADY=1) → WRDATA (WREADY=1) → WRRESP (BVALID=1) → WRIDLE on BREADY. The address is latched on the AW handshake. The register update happens on the W handshake.
- Read FSM states: RDRESET → RDIDLE (ARREADY=1) → RDDATA (RVALID=1, RDATA registered) → RDIDLE on RREADY.
- Start bit:
  - Set by a write to AP_CTRL with WDATA[0]=1 and WSTRB[0]=1.
  - Cleared when `ap_ready`=1 and auto_restart=0.
  - Writing 0 has no effect.
- Done bit:
  - Set on `ap_done`.
  - Cleared on the AR handshake to 0x00.
  - If set and clear occur in the same cycle, set wins. RDATA returns the pre-update value.
- ISR bit n: set when IER[n]=1 and its event (b0 `ap_done`, b1 `ap_ready`) is high. If set and a toggle-write occur in the same cycle, set wins.
- interrupt = GIE & |ISR.

## Timing
- Reset values:
  - AWREADY, WREADY, BVALID, ARREADY, RVALID: 0.
  - RDATA, interrupt, ap_start, xfer_size, gmem_ptr: 0.
  - All internal registers: 0.
  - Both FSMs enter *IDLE on the first clock after reset is released.
- AW and W are never accepted concurrently; AW always precedes W. Minimum write is 3 cycles to BVALID.
- Read latency: RVALID is asserted the cycle after the AR handshake. RVALID and RDATA hold stable until RREADY.
- The `ap_start` output changes the cycle after the W handshake.
- Argument outputs update the cycle after the W handshake. They are not guarded while the core is busy.
- Reset asserted mid-transaction: the transaction is abandoned and all outputs go to reset values immediately (asynchronous reset).

## Structure
- Package `byteswap_control_pkg` holds:
  - Address offset localparams (ADDR_AP_CTRL … ADDR_GMEM_PTR_HI).
  - AP_CTRL bit indices.
  - `wr_state_t` and `rd_state_t` enums.
- No sub-module; both FSMs and the register file live in one module of about 250 lines.

## Test plan
- Reset release, then read 0x00 with the core idle → RDATA=0x4. All argument outputs read 0.
- Write 0x10=0x1000, write 0x18=0x8000_0000, write 0x1C=0x1 → xfer_size=0x1000, gmem_ptr=0x1_8000_0000. Readback matches. A write with WSTRB=4'b0011 to 0x10 with data 0xFFFF_FFFF → 0x0000_FFFF.
- Write 0x00=0x1 → ap_start=1 the next cycle. Pulse ap_ready=ap_done=1 → ap_start=0. The first read of 0x00 returns b1=1; the second read returns b1=0.
- auto_restart: write 0x00=0x81, pulse ap_ready → ap_start stays 1.
- Interrupt: GIE=1, IER=0x1, pulse ap_done → interrupt=1. Write ISR=0x1 → interrupt=0.
- ap_done coincides with the AR handshake to 0x00 → that read returns b1=0 and the following read returns b1=1. Hold BREADY/RREADY low for 5 cycles → BVALID/RVALID are held and no new AW/AR is accepted.
